// File: rtl/lcg_pkg.sv
// rtl/lcg_pkg.sv - shared types and constants for the LCG parameter loader
package lcg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } lcg_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT   = 8'hA5;
  localparam int unsigned FRAME_PAYLOAD_BYTES = 24;
  localparam int unsigned WORD_W              = 32;
  localparam int unsigned NUM_WORDS           = FRAME_PAYLOAD_BYTES / 4;
  localparam int unsigned BYTE_CNT_W          = 5;

  localparam logic [BYTE_CNT_W-1:0] LAST_PAYLOAD_IDX = BYTE_CNT_W'(FRAME_PAYLOAD_BYTES - 1);

endpackage

// File: rtl/lcg_frame_timeout.sv
// rtl/lcg_frame_timeout.sv - loadable down-counter flagging an idle gap inside a frame
module lcg_frame_timeout #(
  parameter int unsigned W = 24
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Flag during the last idle cycle so the owner acts on exactly the Nth idle edge.
  assign expired = en && !load && (count_q <= W'(1));

endmodule

// File: rtl/lcg_param_loader.sv
// rtl/lcg_param_loader.sv - framed byte-stream loader committing LCG parameters to the guesser
module lcg_param_loader
  import lcg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16000000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [WORD_W-1:0] MODULUS,
  output logic [WORD_W-1:0] MULTIPLIER,
  output logic [WORD_W-1:0] INCREMENT,
  output logic [WORD_W-1:0] expected_v0,
  output logic [WORD_W-1:0] expected_v1,
  output logic [WORD_W-1:0] expected_v2,
  output logic              start,
  output logic              params_valid,
  input  logic              scan_done,
  output logic              frame_error
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  lcg_state_t            state_q, state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q;
  logic [7:0]            xor_q;
  logic [WORD_W-1:0]     shadow_q [NUM_WORDS];

  logic accept;
  logic to_expired;
  logic sync_seen;
  logic payload_take;
  logic commit;
  logic reject;
  logic release_hold;

  assign rx_ready = RST_N && (state_q != ST_HOLD);
  assign accept   = rx_valid && rx_ready;

  lcg_frame_timeout #(
    .W (TO_W)
  ) u_timeout (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load       (accept),
    .load_value (TO_W'(TIMEOUT_CYCLES)),
    .en         ((state_q == ST_PAYLOAD) || (state_q == ST_CHECK)),
    .expired    (to_expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sync_seen    = 1'b0;
    payload_take = 1'b0;
    commit       = 1'b0;
    reject       = 1'b0;
    release_hold = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          sync_seen = 1'b1;
          state_d   = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (to_expired) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          payload_take = 1'b1;
          if (byte_cnt_q == LAST_PAYLOAD_IDX) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (to_expired) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          if ((rx_data == xor_q) && (shadow_q[0] != '0)) begin
            commit  = 1'b1;
            state_d = ST_HOLD;
          end else begin
            reject  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (scan_done) begin
          release_hold = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byte_cnt_q   <= '0;
      xor_q        <= '0;
      for (int i = 0; i < NUM_WORDS; i++) shadow_q[i] <= '0;
      MODULUS      <= '0;
      MULTIPLIER   <= '0;
      INCREMENT    <= '0;
      expected_v0  <= '0;
      expected_v1  <= '0;
      expected_v2  <= '0;
      start        <= 1'b0;
      params_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      start <= commit;

      // A fresh sync or an abandoned frame both leave the shadow empty.
      if (sync_seen || to_expired || reject) begin
        byte_cnt_q <= '0;
        xor_q      <= '0;
        for (int i = 0; i < NUM_WORDS; i++) shadow_q[i] <= '0;
      end

      if (payload_take) begin
        shadow_q[byte_cnt_q[4:2]] <= {shadow_q[byte_cnt_q[4:2]][WORD_W-9:0], rx_data};
        xor_q                     <= xor_q ^ rx_data;
        if (byte_cnt_q != LAST_PAYLOAD_IDX) begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
      end

      if (commit) begin
        MODULUS      <= shadow_q[0];
        MULTIPLIER   <= shadow_q[1];
        INCREMENT    <= shadow_q[2];
        expected_v0  <= shadow_q[3];
        expected_v1  <= shadow_q[4];
        expected_v2  <= shadow_q[5];
        params_valid <= 1'b1;
        frame_error  <= 1'b0;
      end

      if (reject || to_expired) begin
        frame_error <= 1'b1;
      end

      if (release_hold) begin
        params_valid <= 1'b0;
      end
    end
  end

endmodule
